vga_timing_gen: RTL and testbench

Pixel-timing generator that sits directly upstream of every background/sprite renderer in the display path. Produces the DrawX/DrawY scan coordinates, the active-video `blank` qualifier and the hsync/vsync pulses for a 640x480@60 Hz raster. Delays sync and blank so they line up with the renderers' ROM-plus-register pipeline. Also emits a per-frame start strobe and a frame counter for animation logic.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/sync_delay.sv | 34 +++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants and small helpers for the VGA timing generator.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Counters are 10 bits wide, so neither total may exceed this.
  localparam int MAX_TOTAL = 1024;
  localparam int MAX_DELAY = 7;

  localparam logic BLANK_INACTIVE = 1'b0;
  localparam logic SYNC_INACTIVE  = 1'b1;

  function automatic logic in_window(logic [9:0] v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that flushes to an inactive level on reset; depth 0 is a gated wire.
`timescale 1ns/1ps
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk;
    assign w_unused_clk = i_clk;
    // Still forced inactive while reset is held so the output never glitches active.
    assign o_q = i_rst ? RESET_VAL : i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with delayed blank/sync aligned to the renderer pipeline.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (BLANK_DELAY < 0 || BLANK_DELAY > MAX_DELAY || SYNC_DELAY < 0 || SYNC_DELAY > MAX_DELAY) begin : g_bad_delay
    $error("vga_timing_gen: BLANK_DELAY/SYNC_DELAY must be 0..7");
  end

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic [7:0] r_frame_count;
  logic       w_h_end;
  logic       w_v_end;
  logic       w_active_raw;
  logic [1:0] w_sync_raw;
  logic [1:0] w_sync_dly;

  assign w_h_end = (r_hc == 10'(H_TOTAL - 1));
  assign w_v_end = (r_vc == 10'(V_TOTAL - 1));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_frame_count <= '0;
    end else if (w_h_end) begin
      r_hc <= '0;
      if (w_v_end) begin
        r_vc          <= '0;
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_vc <= r_vc + 10'd1;
      end
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  assign w_active_raw = (int'(r_hc) < H_VISIBLE) && (int'(r_vc) < V_VISIBLE);
  assign w_sync_raw   = {~in_window(r_hc, HS_START, HS_END), ~in_window(r_vc, VS_START, VS_END)};

  sync_delay #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL ({SYNC_INACTIVE, SYNC_INACTIVE})
  ) u_sync_dly (
    .i_clk (vga_clk),
    .i_rst (reset),
    .i_d   (w_sync_raw),
    .o_q   (w_sync_dly)
  );

  sync_delay #(
    .WIDTH     (1),
    .DEPTH     (BLANK_DELAY),
    .RESET_VAL (BLANK_INACTIVE)
  ) u_blank_dly (
    .i_clk (vga_clk),
    .i_rst (reset),
    .i_d   (w_active_raw),
    .o_q   (blank)
  );

  assign hs = w_sync_dly[1];
  assign vs = w_sync_dly[0];

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign frame_count = r_frame_count;
  // Gated by reset so the (0,0) counters held in reset do not look like a frame start.
  assign frame_start = ~reset && (r_hc == '0) && (r_vc == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, zero-delay and miniature-raster instances vs. an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
    int bd; int sd;
  } tim_t;

  typedef struct {
    int   t;
    out_t e;
  } vec_t;

  localparam int SF = 14 * 10;  // cycles per frame of the miniature instance

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, z_x, z_y, s_x, s_y;
  logic       d_b, d_hs, d_vs, d_fs, z_b, z_hs, z_vs, z_fs, s_b, s_hs, s_vs, s_fs;
  logic [7:0] d_fc, z_fc, s_fc;

  vga_timing_gen dut_def (
    .vga_clk(clk), .reset(rst), .DrawX(d_x), .DrawY(d_y), .blank(d_b), .hs(d_hs), .vs(d_vs),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(.BLANK_DELAY(0), .SYNC_DELAY(0)) dut_z (
    .vga_clk(clk), .reset(rst), .DrawX(z_x), .DrawY(z_y), .blank(z_b), .hs(z_hs), .vs(z_vs),
    .frame_start(z_fs), .frame_count(z_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .vga_clk(clk), .reset(rst), .DrawX(s_x), .DrawY(s_y), .blank(s_b), .hs(s_hs), .vs(s_vs),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  out_t a_def, a_z, a_s;
  assign a_def = {d_x, d_y, d_b, d_hs, d_vs, d_fs, d_fc};
  assign a_z   = {z_x, z_y, z_b, z_hs, z_vs, z_fs, z_fc};
  assign a_s   = {s_x, s_y, s_b, s_hs, s_vs, s_fs, s_fc};

  tim_t P_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2};
  tim_t P_Z   = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
  tim_t P_S   = '{8, 1, 2, 3, 5, 1, 2, 2, 1, 2};

  int   vectors = 0;
  int   miscompares = 0;
  int   t = 0;
  out_t RST;
  vec_t tab_def [15];
  vec_t tab_z   [8];

  function automatic out_t o(int x, int y, int b, int h, int v, int f, int fc);
    out_t r;
    r.x = 10'(x); r.y = 10'(y); r.blank = 1'(b); r.hs = 1'(h); r.vs = 1'(v); r.fs = 1'(f); r.fc = 8'(fc);
    return r;
  endfunction

  // Raster position of cycle tt counted from reset release, derived purely arithmetically.
  function automatic int pos_x(int tt, tim_t p);
    int ht = p.hv + p.hf + p.hsw + p.hb;
    int vt = p.vv + p.vf + p.vsw + p.vb;
    return (tt % (ht * vt)) % ht;
  endfunction

  function automatic int pos_y(int tt, tim_t p);
    int ht = p.hv + p.hf + p.hsw + p.hb;
    int vt = p.vv + p.vf + p.vsw + p.vb;
    return (tt % (ht * vt)) / ht;
  endfunction

  function automatic out_t model(int tt, tim_t p);
    out_t m;
    int   ht = p.hv + p.hf + p.hsw + p.hb;
    int   fr = ht * (p.vv + p.vf + p.vsw + p.vb);
    int   bx, by, sx, sy;
    m.x  = 10'(pos_x(tt, p));
    m.y  = 10'(pos_y(tt, p));
    m.fs = ((tt % fr) == 0);
    m.fc = 8'((tt / fr) % 256);
    if (tt >= p.bd) begin
      bx = pos_x(tt - p.bd, p); by = pos_y(tt - p.bd, p);
      m.blank = (bx < p.hv) && (by < p.vv);
    end else begin
      m.blank = 1'b0;
    end
    if (tt >= p.sd) begin
      sx = pos_x(tt - p.sd, p); sy = pos_y(tt - p.sd, p);
      m.hs = !((sx >= p.hv + p.hf) && (sx < p.hv + p.hf + p.hsw));
      m.vs = !((sy >= p.vv + p.vf) && (sy < p.vv + p.vf + p.vsw));
    end else begin
      m.hs = 1'b1; m.vs = 1'b1;
    end
    return m;
  endfunction

  task automatic check(input string nm, input out_t a, input out_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s t=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, expected x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
               nm, t, a.x, a.y, a.blank, a.hs, a.vs, a.fs, a.fc, e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s t=%0d got %0d, expected %0d", nm, t, a, e);
    end
  endtask

  task automatic check_models(input bit full_on, input bit s_on);
    if (full_on) begin
      check("model_def", a_def, model(t, P_DEF));
      check("model_z", a_z, model(t, P_Z));
    end
    if (s_on) check("model_s", a_s, model(t, P_S));
  endtask

  task automatic check_reset(input string tag);
    check({"rst_def_", tag}, a_def, RST);
    check({"rst_z_", tag}, a_z, RST);
    check({"rst_s_", tag}, a_s, RST);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    t = 0;
  endtask

  task automatic assert_reset_midcycle(input string tag);
    #2 rst = 1'b1;
    #1 check_reset(tag);
  endtask

  initial begin
    int pulses;
    int last_fs;
    int len;
    int hold;

    RST = o(0, 0, 0, 1, 1, 0, 0);
    tab_def[0]  = '{0,    o(0,   0, 0, 1, 1, 1, 0)};
    tab_def[1]  = '{1,    o(1,   0, 1, 1, 1, 0, 0)};
    tab_def[2]  = '{639,  o(639, 0, 1, 1, 1, 0, 0)};
    tab_def[3]  = '{640,  o(640, 0, 1, 1, 1, 0, 0)};
    tab_def[4]  = '{641,  o(641, 0, 0, 1, 1, 0, 0)};
    tab_def[5]  = '{657,  o(657, 0, 0, 1, 1, 0, 0)};
    tab_def[6]  = '{658,  o(658, 0, 0, 0, 1, 0, 0)};
    tab_def[7]  = '{753,  o(753, 0, 0, 0, 1, 0, 0)};
    tab_def[8]  = '{754,  o(754, 0, 0, 1, 1, 0, 0)};
    tab_def[9]  = '{799,  o(799, 0, 0, 1, 1, 0, 0)};
    tab_def[10] = '{800,  o(0,   1, 0, 1, 1, 0, 0)};
    tab_def[11] = '{801,  o(1,   1, 1, 1, 1, 0, 0)};
    tab_def[12] = '{1600, o(0,   2, 0, 1, 1, 0, 0)};
    tab_def[13] = '{2200, o(600, 2, 1, 1, 1, 0, 0)};
    tab_def[14] = '{2300, o(700, 2, 0, 0, 1, 0, 0)};
    tab_z[0] = '{0,   o(0,   0, 1, 1, 1, 1, 0)};
    tab_z[1] = '{639, o(639, 0, 1, 1, 1, 0, 0)};
    tab_z[2] = '{640, o(640, 0, 0, 1, 1, 0, 0)};
    tab_z[3] = '{655, o(655, 0, 0, 1, 1, 0, 0)};
    tab_z[4] = '{656, o(656, 0, 0, 0, 1, 0, 0)};
    tab_z[5] = '{751, o(751, 0, 0, 0, 1, 0, 0)};
    tab_z[6] = '{752, o(752, 0, 0, 1, 1, 0, 0)};
    tab_z[7] = '{800, o(0,   1, 1, 1, 1, 0, 0)};

    // Power-on reset held for 10 clocks.
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_reset("hold");
    end
    release_reset();

    // Line scans of the full-size instances against fixed vectors and the model.
    for (int c = 0; c <= 2300; c++) begin
      @(negedge clk);
      t = c;
      check_models(1'b1, 1'b1);
      foreach (tab_def[i]) if (tab_def[i].t == t) check("tab_def", a_def, tab_def[i].e);
      foreach (tab_z[i])   if (tab_z[i].t == t)   check("tab_z", a_z, tab_z[i].e);
    end
    // DrawX=700 sits inside hsync: reset must kill the pulse immediately.
    assert_reset_midcycle("in_hsync");
    repeat (3) @(posedge clk);
    release_reset();

    // Miniature raster: reset while both hsync and vsync are low.
    for (int c = 0; c <= 96; c++) begin
      @(negedge clk);
      t = c;
      check_models(1'b1, 1'b1);
    end
    check("s_in_both_sync", a_s, o(12, 6, 0, 0, 0, 0, 0));
    assert_reset_midcycle("in_vsync");
    @(posedge clk);
    release_reset();

    // Random run lengths with random reset hold times.
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(2000, 20);
      for (int c = 0; c <= len; c++) begin
        @(negedge clk);
        t = c;
        check_models(1'b1, 1'b1);
      end
      assert_reset_midcycle("random");
      hold = $urandom_range(4, 1);
      repeat (hold) begin
        @(negedge clk);
        check_reset("random_hold");
      end
      release_reset();
    end

    // 257 frame wraps on the miniature raster: strobe spacing and frame_count wrap.
    pulses  = 0;
    last_fs = 0;
    for (int c = 0; c <= 257 * SF; c++) begin
      @(negedge clk);
      t = c;
      check_models(c < 1000, (c < 3 * SF) || ((c % SF) < 2));
      if (c > 0 && s_fs) begin
        pulses++;
        check_int("fs_spacing", c - last_fs, SF);
        last_fs = c;
      end
    end
    check_int("fs_pulses", pulses, 257);
    check_int("fc_after_257", int'(s_fc), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
